// File: rtl/lrhls_mac_pipe.sv
// lrhls_mac_pipe: pipelined signed multiply-accumulate with valid/ready handshakes and full backpressure.
// Build option LRHLS_MAC_SAT_EN: saturating accumulation with a sticky overflow flag (default wraps).
module lrhls_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int NUM_STAGE = 3
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  input  logic                        in_clr,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] dout,
  output logic                        dout_ovf
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  generate
    if (ACC_WIDTH < P_WIDTH) begin : g_bad_acc_width
      $error("lrhls_mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_num_stage
      $error("lrhls_mac_pipe: NUM_STAGE must be in 1..4");
    end
  endgenerate

  logic                         en;
  logic                         vld_p0;
  logic                         clr_p0;
  logic                         last_p0;
  logic signed [A_WIDTH-1:0]    a_p0;
  logic signed [B_WIDTH-1:0]    b_p0;
  logic signed [P_WIDTH-1:0]    mult_p0;

  logic [NUM_STAGE-1:0]         vld_pipe;
  logic [NUM_STAGE-1:0]         clr_pipe;
  logic [NUM_STAGE-1:0]         last_pipe;
  logic signed [P_WIDTH-1:0]    prod_pipe [NUM_STAGE];

  logic                         vld_acc;
  logic                         clr_acc;
  logic                         last_acc;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_next;

  // One global enable freezes every stage while a result waits downstream.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage boundary: operand capture -> multiplier pipeline -> accumulate.
  assign mult_p0 = P_WIDTH'(a_p0) * P_WIDTH'(b_p0);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_p0   <= 1'b0;
      vld_pipe <= '0;
    end else if (en) begin
      vld_p0      <= in_valid;
      vld_pipe[0] <= vld_p0;
      for (int s = 1; s < NUM_STAGE; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (en) begin
      a_p0         <= din0;
      b_p0         <= din1;
      clr_p0       <= in_clr;
      last_p0      <= in_last;
      prod_pipe[0] <= mult_p0;
      clr_pipe[0]  <= clr_p0;
      last_pipe[0] <= last_p0;
      for (int s = 1; s < NUM_STAGE; s++) begin
        prod_pipe[s] <= prod_pipe[s-1];
        clr_pipe[s]  <= clr_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
      end
    end
  end

  // Stage boundary: accumulate / result register.
  assign vld_acc  = vld_pipe[NUM_STAGE-1];
  assign clr_acc  = clr_pipe[NUM_STAGE-1];
  assign last_acc = last_pipe[NUM_STAGE-1];
  assign prod_ext = ACC_WIDTH'(prod_pipe[NUM_STAGE-1]);

`ifdef LRHLS_MAC_SAT_EN
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] s);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      sat_acc = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sat_acc = s[ACC_WIDTH-1:0];
    end
  endfunction

  logic signed [ACC_WIDTH:0] sum_wide;
  logic                      ovf_q;
  logic                      ovf_next;

  assign sum_wide = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod_ext);

  // A fresh product alone always fits, so only the running sum can overflow.
  always_comb begin
    acc_next = clr_acc ? prod_ext : sat_acc(sum_wide);
    ovf_next = !clr_acc && (ovf_q || (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_q    <= 1'b0;
      dout_ovf <= 1'b0;
    end else if (en && vld_acc) begin
      if (last_acc) begin
        ovf_q    <= 1'b0;
        dout_ovf <= ovf_next;
      end else begin
        ovf_q    <= ovf_next;
      end
    end
  end
`else
  assign acc_next = clr_acc ? prod_ext : acc + prod_ext;
  assign dout_ovf = 1'b0;
`endif

  // A new result load wins over a drain, so out_valid simply follows the load.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= vld_acc && last_acc;
      if (vld_acc) begin
        if (last_acc) begin
          dout <= acc_next;
          acc  <= '0;
        end else begin
          acc  <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_lrhls_mac_pipe.sv
// tb_lrhls_mac_pipe: directed bench for lrhls_mac_pipe, default widths plus a 36-bit accumulator copy.
// Expected saturation results depend on whether LRHLS_MAC_SAT_EN is defined.
module tb_lrhls_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;

  typedef struct {
    longint d48;
    logic   o48;
    longint d36;
    logic   o36;
    int     cyc;
  } res_t;

  logic                 ap_clk   = 1'b0;
  logic                 ap_rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_clr   = 1'b0;
  logic                 in_last  = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [AW-1:0] din0 = '0;
  logic signed [BW-1:0] din1 = '0;

  logic                 in_ready, out_valid, dout_ovf;
  logic signed [47:0]   dout;
  logic                 in_ready36, out_valid36, dout_ovf36;
  logic signed [35:0]   dout36;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     bp_cnt = 0;
  logic   rdy_rand = 1'b0;
  logic   bp_on = 1'b0;
  logic   stall_prev = 1'b0;
  logic signed [47:0] dout_prev = '0;
  res_t   q[$];

  lrhls_mac_pipe dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .in_clr(in_clr), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .dout_ovf(dout_ovf)
  );

  lrhls_mac_pipe #(.ACC_WIDTH(36)) dut36 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready36),
    .din0(din0), .din1(din1), .in_clr(in_clr), .in_last(in_last),
    .out_valid(out_valid36), .out_ready(out_ready), .dout(dout36), .dout_ovf(dout_ovf36)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Handshakes are recorded at the falling edge; out_ready only changes just after a rising edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid && out_ready)
      q.push_back('{longint'(dout), dout_ovf, longint'(dout36), dout_ovf36, cyc});
    if (bp_on) begin
      check_val("bp_in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
      if (stall_prev) begin
        check_val("stall_dout", longint'(dout), longint'(dout_prev));
        check_val("stall_vld", longint'(out_valid), 1);
      end
    end
    stall_prev = out_valid && !out_ready;
    dout_prev  = dout;
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
    if (rdy_rand) begin
      bp_cnt++;
      out_ready = (bp_cnt >= 5 && bp_cnt < 15) ? 1'b0 : 1'($urandom % 2);
    end
    #1;
  endtask

  task automatic send(input int a, input int b, input logic c, input logic l);
    din0 = AW'(a);
    din1 = BW'(b);
    in_clr = c;
    in_last = l;
    in_valid = 1'b1;
    for (int t = 0; t < 1000 && !in_ready; t++) step();
    if (!in_ready) check_val("send_ready", longint'(in_ready), 1);
    step();
    in_valid = 1'b0;
    in_clr = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_results(input int n, input int bound);
    for (int t = 0; t < bound && q.size() < n; t++) step();
    check_val("res_count", q.size(), n);
  endtask

  initial begin
    int n;

    repeat (3) step();
    ap_rst_n = 1'b1;
    step();
    check_val("rst_in_ready", longint'(in_ready), 1);
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_dout", longint'(dout), 0);
    check_val("rst_dout_ovf", longint'(dout_ovf), 0);

    // Single full-scale product and its latency.
    send(-131072, -131072, 1'b1, 1'b1);
    n = 0;
    while (n < 20 && !out_valid) begin
      step();
      n++;
    end
    check_val("lat_cycles", n, 4);
    check_val("single_dout", longint'(dout), 64'sd17179869184);
    check_val("single_ovf", longint'(dout_ovf), 0);
    check_val("single_dout36", longint'(dout36), 64'sd17179869184);
    step();
    q.delete();

    // Dot product followed immediately by a one-beat group.
    send(3, 4, 1'b1, 1'b0);
    send(-5, 6, 1'b0, 1'b0);
    send(7, -8, 1'b0, 1'b0);
    send(100, 100, 1'b0, 1'b1);
    send(1, 1, 1'b1, 1'b1);
    wait_results(2, 50);
    if (q.size() >= 2) begin
      check_val("dot_dout", q[0].d48, 9926);
      check_val("dot2_dout", q[1].d48, 1);
      check_val("dot2_next_cycle", q[1].cyc - q[0].cyc, 1);
    end
    step();
    q.delete();

    // Backpressure: random out_ready with a 10-cycle hold-low window.
    bp_cnt = 0;
    rdy_rand = 1'b1;
    bp_on = 1'b1;
    for (int i = 0; i < 20; i++) send(i, 2, 1'b1, 1'b1);
    wait_results(20, 1000);
    rdy_rand = 1'b0;
    bp_on = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && i < q.size(); i++)
      check_val($sformatf("bp_res%0d", i), q[i].d48, 2 * i);
    step();
    step();
    q.delete();

    // Saturation / wrap on the 36-bit accumulator.
    send(-131072, -131072, 1'b1, 1'b0);
    send(-131072, -131072, 1'b0, 1'b1);
    wait_results(1, 50);
    if (q.size() >= 1) begin
      check_val("sat48_dout", q[0].d48, 64'sd34359738368);
      check_val("sat48_ovf", longint'(q[0].o48), 0);
`ifdef LRHLS_MAC_SAT_EN
      check_val("sat36_dout", q[0].d36, 64'sd34359738367);
      check_val("sat36_ovf", longint'(q[0].o36), 1);
`else
      check_val("sat36_dout", q[0].d36, -64'sd34359738368);
      check_val("sat36_ovf", longint'(q[0].o36), 0);
`endif
    end
    step();
    q.delete();

    // Reset after a partial sum has built up: the next last beat must not add onto it.
    send(5, 5, 1'b0, 1'b0);
    send(5, 5, 1'b0, 1'b0);
    repeat (6) step();
    ap_rst_n = 1'b0;
    #1;
    check_val("rstA_during_vld", longint'(out_valid), 0);
    step();
    ap_rst_n = 1'b1;
    check_val("rstA_in_ready", longint'(in_ready), 1);
    check_val("rstA_out_vld", longint'(out_valid), 0);
    send(2, 3, 1'b0, 1'b1);
    wait_results(1, 50);
    if (q.size() >= 1) check_val("rstA_dout", q[0].d48, 6);
    step();
    q.delete();

    // Reset with beats still in flight.
    send(5, 5, 1'b0, 1'b0);
    send(5, 5, 1'b0, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    check_val("rstB_during_vld", longint'(out_valid), 0);
    step();
    ap_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("rstB_after_vld", longint'(out_valid), 0);
    end
    send(2, 3, 1'b1, 1'b1);
    wait_results(1, 50);
    if (q.size() >= 1) check_val("rstB_dout", q[0].d48, 6);
    step();
    q.delete();

    // Simultaneous drain and load.
    send(10, 10, 1'b1, 1'b1);
    send(3, 3, 1'b1, 1'b1);
    for (int t = 0; t < 20 && !out_valid; t++) step();
    check_val("dl_first_vld", longint'(out_valid), 1);
    check_val("dl_first_dout", longint'(dout), 100);
    step();
    check_val("dl_second_vld", longint'(out_valid), 1);
    check_val("dl_second_dout", longint'(dout), 9);
    step();
    check_val("dl_drained_vld", longint'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lrhls_mac_pipe.md
# lrhls_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit with valid/ready handshakes. It generalises the fixed 18x18 combinational DSP48 multiplier used in the LRHLS_top linear-regression datapath. Widths, pipeline depth and accumulation length are configurable, and full backpressure is supported. It sits between the hit-stream unpacker and the regression-sum registers, and produces sums of products (Σx·y, Σx², …) per track candidate.

## Interface
Parameters:
- A_WIDTH, 18, signed width of din0.
- B_WIDTH, 18, signed width of din1.
- ACC_WIDTH, 48, accumulator/result width. Must be ≥ A_WIDTH+B_WIDTH; a smaller value is an elaboration error.
- NUM_STAGE, 3, multiplier pipeline register stages, legal range 1..4.

Ports:
- ap_clk  in  1  single clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- din0  in  A_WIDTH  signed operand a.
- din1  in  B_WIDTH  signed operand b.
- in_clr  in  1  beat starts a new accumulation.
- in_last  in  1  beat ends the accumulation; emits the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- dout  out  ACC_WIDTH  signed accumulated result.
- dout_ovf  out  1  overflow occurred in this accumulation (saturation builds only).

## Operation
- Global enable: en = !out_valid || out_ready. in_ready = en. All pipeline stages advance only when en=1.
- A beat is accepted when in_valid && in_ready. Its operands, clr, last and a valid bit enter stage 1.
- The product is a full signed A_WIDTH+B_WIDTH multiply. It is sign-extended to ACC_WIDTH.
- The accumulate stage consumes a valid product when en=1:
  - acc_next = in_clr ? prod : acc + prod.
  - If last=0: acc <= acc_next.
  - If last=1: dout <= acc_next, dout_ovf <= ovf_next, out_valid <= 1, and acc <= 0.
- A beat with clr=1 and last=1 yields a single plain product.
- A beat with neither flag, arriving after a completed result, adds onto acc=0.
- Output drain: if out_valid && out_ready and no new result loads in the same cycle, out_valid <= 0.
  - Simultaneous drain and load: out_valid stays 1 and dout takes the new value.
- dout and dout_ovf hold stable while out_valid=1 && out_ready=0.
- Invalid bubbles propagate through the pipeline without touching acc.
- Reset (async assert, any time):
  - All stage valid bits 0, acc=0, out_valid=0, dout=0, dout_ovf=0.
  - in_ready=1 from the first edge after deassertion.
  - In-flight beats and any partial accumulation are discarded.

## Timing
- Latency: a beat accepted at edge k with last=1 gives out_valid=1 after edge k+NUM_STAGE+1, provided no stall occurs.
- Throughput: one beat per cycle while out_ready=1 or out_valid=0.
- Stalls freeze every stage. No bubble is inserted and no beat is lost or reordered.
- in_ready is combinational from out_valid/out_ready only. There is no combinational path from in_valid to out_valid.
- Reset values: in_ready=1, out_valid=0, dout=0, dout_ovf=0.

## Configuration
- LRHLS_MAC_SAT_EN defined:
  - Sum computed in ACC_WIDTH+1 bits.
  - On signed overflow, acc_next clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - A sticky ovf flag is set. It clears on a clr beat or after last, and is reported on dout_ovf with the result.
- LRHLS_MAC_SAT_EN undefined:
  - Accumulator wraps modulo 2^ACC_WIDTH.
  - dout_ovf tied to 0.
  - No saturation logic is synthesised.

## Test plan
- Single product, defaults: din0=-131072, din1=-131072, clr=last=1 -> dout=17179869184, dout_ovf=0, out_valid exactly 4 cycles after acceptance.
- Dot product: (3,4) clr, (-5,6), (7,-8), (100,100) last, back-to-back -> one result, dout=9926. A second immediate group (1,1) clr+last -> dout=1 on the next cycle.
- Backpressure: stream of 20 clr+last beats (i,2) with out_ready random/held low 10 cycles -> in_ready low while out_valid && !out_ready, dout stable during stall, results 0,2,4,…,38 in order with none lost.
- Saturation, ACC_WIDTH=36: two beats (-131072,-131072) clr then last -> with LRHLS_MAC_SAT_EN dout=34359738367 and dout_ovf=1; without it dout=-34359738368 and dout_ovf=0.
- Reset mid-accumulation: two non-last beats (5,5), assert ap_rst_n=0 for 1 cycle, then (2,3) clr+last -> out_valid=0 during and after reset until the result, then dout=6.
- Simultaneous drain/load: out_valid=1, out_ready=1 while a last beat reaches the accumulate stage -> out_valid stays 1 and dout updates to the new sum on the same edge.
